wa_write_buffer: RTL

WA_WRITE_BUFFER -- requirements
Module: wa_write_buffer

---
 rtl/wa_write_buffer_if.sv | 18 +
 rtl/wa_write_buffer.sv | 52 +++++
 2 files changed

// File: rtl/wa_write_buffer_if.sv
// wa_write_buffer_if: SIF write-address port and target-memory request bus.
interface wa_write_buffer_if;
    logic        wa_wr_s;
    logic [15:0] wa_addr;
    logic [15:0] wa_data_wr;
    logic        mem_wr_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ack;
    modport slave (
        input  wa_wr_s, wa_addr, wa_data_wr, mem_ack,
        output mem_wr_en, mem_addr, mem_data
    );
    modport master (
        output wa_wr_s, wa_addr, wa_data_wr, mem_ack,
        input  mem_wr_en, mem_addr, mem_data
    );
endinterface

// File: rtl/wa_write_buffer.sv
// wa_write_buffer: posted-write FIFO between SIF writes and a target memory handshake.
module wa_write_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    wa_write_buffer_if.slave         bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, REQ} state_t;
    state_t state, state_n;
    logic [31:0]   fifo [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          push, pop, drop;
    assign full          = count == (AW+1)'(DEPTH);
    assign bus.mem_wr_en = state == REQ;
    // a pop refills the output register, so a full FIFO can still accept on that edge
    always_comb begin
        pop     = (count != '0) && (state == IDLE || bus.mem_ack);
        push    = bus.wa_wr_s && (!full || pop);
        drop    = bus.wa_wr_s && full && !pop;
        state_n = pop ? REQ : (bus.mem_ack ? IDLE : state);
    end
    always_ff @(posedge clk)
        if (push) fifo[wp] <= {bus.wa_addr, bus.wa_data_wr};
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wp           <= '0;
            rp           <= '0;
            count        <= '0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
            overflow     <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            state <= state_n;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp                         <= rp + 1'b1;
                {bus.mem_addr, bus.mem_data} <= fifo[rp];
            end
            if (drop) overflow <= 1'b1;
            if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule
